// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder: data-bus target backed by a word-addressed SRAM model.
// Requests are accepted in IDLE and answered after a programmable latency.
// An aborted or reset request never touches the array.
// Optional build macro: DBUS_RAND_DELAY_EN (LFSR-randomised latency in 1..LATENCY).

package dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module dbus_sram_responder
  import dbus_pkg::*;
#(
  parameter int          WORDS   = 4096,
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int          LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       oob
);

  localparam int IW = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          inr_q, inr_d;
  logic          wr_q, wr_d;
  logic [7:0]    strb_q, strb_d;
  logic [63:0]   wdata_q, wdata_d;
  logic          addr_ok_q, addr_ok_d;
  logic          data_ok_q, data_ok_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          oob_q, oob_d;

  logic [63:0]   mem [WORDS];

  // Address decode of the incoming request (wraps in 64-bit arithmetic).
  logic [63:0] off, word;
  logic        acc_inr;
  assign off     = dreq.addr - BASE;
  assign word    = off >> 3;
  assign acc_inr = (dreq.addr >= BASE) && (word < 64'(WORDS));

  // The core picks its own lanes out of the full word, so size is not needed.
  logic unused_size;
  assign unused_size = ^dreq.size;

  // Countdown value loaded at acceptance (latency minus one).
  logic [3:0] lat_m1;
`ifdef DBUS_RAND_DELAY_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lat_m1 = 4'(32'(lfsr_q[3:0]) % LATENCY);
`else
  assign lat_m1 = 4'(LATENCY - 1);
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    inr_d     = inr_q;
    wr_d      = wr_q;
    strb_d    = strb_q;
    wdata_d   = wdata_q;
    addr_ok_d = 1'b0;
    data_ok_d = 1'b0;
    rdata_d   = '0;
    oob_d     = 1'b0;
`ifdef DBUS_RAND_DELAY_EN
    lfsr_d    = lfsr_q;
`endif
    case (state_q)
      IDLE: if (dreq.valid) begin
        idx_d   = word[IW-1:0];
        inr_d   = acc_inr;
        wr_d    = |dreq.strobe;
        strb_d  = dreq.strobe;
        wdata_d = dreq.data;
        cnt_d   = lat_m1;
        state_d = (lat_m1 == 4'd0) ? RESP : WAIT;
`ifdef DBUS_RAND_DELAY_EN
        lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`endif
      end
      WAIT: begin
        if (!dreq.valid) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Response flops load on entry to RESP so they are valid during it.
    if (state_d == RESP) begin
      addr_ok_d = 1'b1;
      data_ok_d = 1'b1;
      oob_d     = !inr_d;
      rdata_d   = (!wr_d && inr_d) ? mem[idx_d] : 64'd0;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      inr_q     <= 1'b0;
      wr_q      <= 1'b0;
      strb_q    <= '0;
      wdata_q   <= '0;
      addr_ok_q <= 1'b0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
      oob_q     <= 1'b0;
`ifdef DBUS_RAND_DELAY_EN
      lfsr_q    <= 16'hACE1;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      inr_q     <= inr_d;
      wr_q      <= wr_d;
      strb_q    <= strb_d;
      wdata_q   <= wdata_d;
      addr_ok_q <= addr_ok_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
      oob_q     <= oob_d;
`ifdef DBUS_RAND_DELAY_EN
      lfsr_q    <= lfsr_d;
`endif
    end
  end

  // Array write commits at the end of the RESP cycle, byte-masked; no reset on contents.
  always_ff @(posedge clk) begin
    if (!reset && state_q == RESP && wr_q && inr_q) begin
      for (int i = 0; i < 8; i++) begin
        if (strb_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign dresp.addr_ok = addr_ok_q;
  assign dresp.data_ok = data_ok_q;
  assign dresp.data    = rdata_q;
  assign oob           = oob_q;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed bench for dbus_sram_responder (default build, LATENCY=2).
module tb_dbus_sram_responder;
  import dbus_pkg::*;

  localparam int LAT = 2;

  logic       clk;
  logic       reset;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic       oob;

  int checks   = 0;
  int failures = 0;

  dbus_sram_responder dut (
    .clk   (clk),
    .reset (reset),
    .dreq  (dreq),
    .dresp (dresp),
    .oob   (oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [63:0] exp_data;
    logic        exp_oob;
    string       name;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // One full transaction with valid held until data_ok, then dropped.
  task automatic txn(input vec_t v);
    int lat;
    lat = -1;
    @(posedge clk); #1;
    dreq = '{valid: 1'b1, addr: v.addr, size: 3'd3,
             strobe: v.wr ? v.strobe : 8'h00, data: v.data};
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (dresp.data_ok) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    chk({v.name, " latency"}, 64'(lat), 64'(LAT));
    if (lat >= 0) begin
      chk({v.name, " data"}, dresp.data, v.exp_data);
      chk({v.name, " oob"}, 64'(oob), 64'(v.exp_oob));
      chk({v.name, " addr_ok"}, 64'(dresp.addr_ok), 64'd1);
    end
    @(posedge clk); #1;
    dreq.valid = 1'b0;
    @(negedge clk);
    chk({v.name, " one-cycle"}, 64'(dresp.data_ok), 64'd0);
  endtask

  vec_t vecs [13];

  initial begin
    int    seen;
    logic [7:0] mask;
    vec_t  v;

    vecs[0]  = '{1'b1, 64'h8000_0008, 8'hFF, 64'h1122334455667788, 64'h0,                1'b0, "w_full"};
    vecs[1]  = '{1'b0, 64'h8000_0008, 8'h00, 64'h0,                64'h1122334455667788, 1'b0, "r_full"};
    vecs[2]  = '{1'b1, 64'h8000_0008, 8'h0F, 64'hAAAABBBBCCCCDDDD, 64'h0,                1'b0, "w_part"};
    vecs[3]  = '{1'b0, 64'h8000_000D, 8'h00, 64'h0,                64'h11223344CCCCDDDD, 1'b0, "r_part_unal"};
    vecs[4]  = '{1'b1, 64'h8000_0000, 8'hFF, 64'h0102030405060708, 64'h0,                1'b0, "w_word0"};
    vecs[5]  = '{1'b1, 64'h8000_7FF8, 8'hFF, 64'hCAFEF00D12345678, 64'h0,                1'b0, "w_last"};
    vecs[6]  = '{1'b0, 64'h8000_7FF8, 8'h00, 64'h0,                64'hCAFEF00D12345678, 1'b0, "r_last"};
    vecs[7]  = '{1'b0, 64'h7FFF_FFF8, 8'h00, 64'h0,                64'h0,                1'b1, "r_below"};
    vecs[8]  = '{1'b0, 64'h8000_8000, 8'h00, 64'h0,                64'h0,                1'b1, "r_above"};
    vecs[9]  = '{1'b1, 64'h7FFF_FFF8, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 64'h0,                1'b1, "w_below"};
    vecs[10] = '{1'b1, 64'h8000_8000, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 64'h0,                1'b1, "w_above"};
    vecs[11] = '{1'b0, 64'h8000_0000, 8'h00, 64'h0,                64'h0102030405060708, 1'b0, "r_word0_kept"};
    vecs[12] = '{1'b0, 64'h8000_7FF8, 8'h00, 64'h0,                64'hCAFEF00D12345678, 1'b0, "r_last_kept"};

    reset = 1'b1;
    dreq  = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset outputs", {dresp.addr_ok, dresp.data_ok, oob, dresp.data}, 67'd0);

    for (int i = 0; i < 13; i++) txn(vecs[i]);

    // Write aborted in WAIT: no response, array untouched.
    @(posedge clk); #1;
    dreq = '{valid: 1'b1, addr: 64'h8000_0008, size: 3'd3, strobe: 8'hFF, data: 64'hFFFFFFFFFFFFFFFF};
    @(posedge clk); #1;
    dreq.valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (dresp.data_ok) seen++;
    end
    chk("abort no data_ok", 64'(seen), 64'd0);
    v = '{1'b0, 64'h8000_0008, 8'h00, 64'h0, 64'h11223344CCCCDDDD, 1'b0, "r_after_abort"};
    txn(v);

    // Reset during WAIT of a write: outputs clear, write discarded.
    @(posedge clk); #1;
    dreq = '{valid: 1'b1, addr: 64'h8000_0000, size: 3'd3, strobe: 8'hFF, data: 64'h5555555555555555};
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    dreq.valid = 1'b0;
    @(negedge clk);
    chk("reset in WAIT outputs", {dresp.addr_ok, dresp.data_ok, oob, dresp.data}, 67'd0);
    repeat (2) @(posedge clk);
    v = '{1'b0, 64'h8000_0000, 8'h00, 64'h0, 64'h0102030405060708, 1'b0, "r_after_reset"};
    txn(v);

    // Back-to-back reads with valid held: data_ok at T+2 and T+5.
    @(posedge clk); #1;
    dreq = '{valid: 1'b1, addr: 64'h8000_0008, size: 3'd3, strobe: 8'h00, data: 64'h0};
    mask = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      mask[k] = dresp.data_ok;
      if (k == 5) chk("b2b second data", dresp.data, 64'h11223344CCCCDDDD);
      @(posedge clk); #1;
    end
    dreq.valid = 1'b0;
    chk("b2b data_ok pattern", 64'(mask), 64'h24);
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
